// File: rtl/cpu_stack.sv
// Operand stack for the stack-machine pipeline: pop-then-push commit from 5a, top-of-stack view and hazard stall for 2a.
// Optional CPU_STACK_BYPASS_EN forwards the 5a commit into top_2a and drops the 5a stall term.
module cpu_stack #(
  parameter int WIDTH      = 35,
  parameter int DEPTH      = 64,
  parameter int CNT_W      = 7,
  parameter int POP_W      = 11,
  parameter int READ_PORTS = 2,
  parameter int INFLIGHT   = 2
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          push_5a,
  input  logic [WIDTH-1:0]              to_push_5a,
  input  logic                          pop_5a,
  input  logic [POP_W-1:0]              to_pop_5a,
  input  logic [INFLIGHT-1:0]           inflight_mod,
  input  logic [2:0]                    need_2a,
  input  logic                          clear,
  output logic [READ_PORTS*WIDTH-1:0]   top_2a,
  output logic [CNT_W-1:0]              count,
  output logic                          stall_2a,
  output logic                          fault,
  output logic [1:0]                    fault_cause
);

`ifdef CPU_STACK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Pop count and occupancy are compared at the wider of the two so huge pops still underflow.
  localparam int FW = (POP_W > CNT_W + 1) ? POP_W : CNT_W + 1;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_OVERFLOW  = 2'b01;
  localparam logic [1:0] CAUSE_UNDERFLOW = 2'b10;

  typedef enum logic {NORMAL = 1'b0, FAULTED = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             active;
  logic [FW-1:0]    pop_f, cnt_f, after_pop_f, after_push_f;
  logic             underflow, overflow, do_push;
  logic [CNT_W-1:0] next_count, view_count, idx;
  logic [2:0]       need_eff;
  logic             commit_term;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    active       = (state == NORMAL) && !clear;
    pop_f        = pop_5a ? FW'(to_pop_5a) : '0;
    cnt_f        = FW'(count);
    after_pop_f  = cnt_f - pop_f;
    after_push_f = after_pop_f + FW'(push_5a);
    underflow    = active && (pop_f > cnt_f);
    overflow     = active && !underflow && push_5a && (after_push_f > FW'(DEPTH));
    do_push      = active && push_5a && !underflow && !overflow;

    if (clear || underflow) next_count = '0;
    else if (!active)       next_count = count;
    else if (do_push)       next_count = CNT_W'(after_push_f);
    else                    next_count = CNT_W'(after_pop_f);
  end

  always_comb begin
    top_2a     = '0;
    idx        = '0;
    view_count = BYPASS ? next_count : count;
    for (int k = 0; k < READ_PORTS; k++) begin
      idx = view_count - CNT_W'(k + 1);
      if (CNT_W'(k) < view_count) begin
        if (BYPASS && do_push && (k == 0)) top_2a[k*WIDTH +: WIDTH] = to_push_5a;
        else                               top_2a[k*WIDTH +: WIDTH] = mem[idx[AW-1:0]];
      end
    end
  end

  always_comb begin
    need_eff    = (need_2a > 3'(READ_PORTS)) ? 3'(READ_PORTS) : need_2a;
    commit_term = BYPASS ? 1'b0 : (push_5a || pop_5a);
    stall_2a    = (state == FAULTED) ||
                  ((need_eff != 3'd0) && ((|inflight_mod) || commit_term));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= NORMAL;
      count       <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else if (clear) begin
      state       <= NORMAL;
      count       <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else if (state == NORMAL) begin
      count <= next_count;
      if (underflow) begin
        state       <= FAULTED;
        fault       <= 1'b1;
        fault_cause <= CAUSE_UNDERFLOW;
      end else if (overflow) begin
        state       <= FAULTED;
        fault       <= 1'b1;
        fault_cause <= CAUSE_OVERFLOW;
      end
    end
  end

  // NOTE: the storage array has no reset; entries above count are never observed.
  always_ff @(posedge clk) begin
    if (rst_b && do_push) mem[after_pop_f[AW-1:0]] <= to_push_5a;
  end

endmodule

// File: tb/tb_cpu_stack.sv
// Self-checking bench for cpu_stack: directed scenarios plus randomized traffic against a queue-based model.
module tb_cpu_stack;
  localparam int W  = 35;
  localparam int D  = 64;
  localparam int CW = 7;
  localparam int P  = 11;
  localparam int RP = 2;
  localparam int IF = 2;
`ifdef CPU_STACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_b, push_5a, pop_5a, clear, stall_2a, fault;
  logic [W-1:0]    to_push_5a;
  logic [P-1:0]    to_pop_5a;
  logic [IF-1:0]   inflight_mod;
  logic [2:0]      need_2a;
  logic [RP*W-1:0] top_2a;
  logic [CW-1:0]   count;
  logic [1:0]      fault_cause;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: queue back is top of stack.
  logic [W-1:0] mq[$], nq[$];
  logic         mfault, nfault;
  logic [1:0]   mcause, ncause;

  cpu_stack #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .POP_W(P), .READ_PORTS(RP), .INFLIGHT(IF)) dut (
    .clk(clk), .rst_b(rst_b), .push_5a(push_5a), .to_push_5a(to_push_5a), .pop_5a(pop_5a),
    .to_pop_5a(to_pop_5a), .inflight_mod(inflight_mod), .need_2a(need_2a), .clear(clear),
    .top_2a(top_2a), .count(count), .stall_2a(stall_2a), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] slice_of(input int k, input bit from_next);
    if (from_next) return (k < nq.size()) ? nq[nq.size()-1-k] : '0;
    return (k < mq.size()) ? mq[mq.size()-1-k] : '0;
  endfunction

  task automatic model_next(input logic psh, input logic [W-1:0] v, input logic pp,
                            input logic [P-1:0] n, input logic clr);
    nq = mq; nfault = mfault; ncause = mcause;
    if (clr) begin
      nq.delete(); nfault = 1'b0; ncause = 2'b00;
    end else if (!mfault) begin
      if (pp && (int'(n) > mq.size())) begin
        nq.delete(); nfault = 1'b1; ncause = 2'b10;
      end else begin
        if (pp) repeat (int'(n)) void'(nq.pop_back());
        if (psh) begin
          if (nq.size() >= D) begin nfault = 1'b1; ncause = 2'b01; end
          else nq.push_back(v);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    push_5a = 0; to_push_5a = '0; pop_5a = 0; to_pop_5a = '0;
    clear = 0; need_2a = 0; inflight_mod = '0;
  endtask

  // One clock of stimulus; checks combinational outputs mid-cycle and registered outputs after the edge.
  task automatic cycle(input logic psh, input logic [W-1:0] v, input logic pp, input logic [P-1:0] n,
                       input logic clr, input logic [2:0] nd, input logic [IF-1:0] inf);
    logic         exp_stall;
    logic [W-1:0] exp_top;
    push_5a = psh; to_push_5a = v; pop_5a = pp; to_pop_5a = n;
    clear = clr; need_2a = nd; inflight_mod = inf;
    model_next(psh, v, pp, n, clr);
    @(negedge clk);
    exp_stall = mfault || ((nd != 0) && ((inf != 0) || (!BYP && (psh || pp))));
    n_checks++;
    if (stall_2a !== exp_stall) $display("FAIL stall_2a: got %b want %b", stall_2a, exp_stall);
    else n_pass++;
    for (int k = 0; k < RP; k++) begin
      exp_top = slice_of(k, BYP);
      n_checks++;
      if (top_2a[k*W +: W] !== exp_top)
        $display("FAIL top_slice%0d: got %h want %h", k, top_2a[k*W +: W], exp_top);
      else n_pass++;
    end
    @(posedge clk);
    mq = nq; mfault = nfault; mcause = ncause;
    #1;
    n_checks++;
    if (count !== CW'(mq.size())) $display("FAIL count: got %0d want %0d", count, mq.size());
    else n_pass++;
    n_checks++;
    if (fault !== mfault || fault_cause !== mcause)
      $display("FAIL fault: got %b/%b want %b/%b", fault, fault_cause, mfault, mcause);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst_b = 0;
    @(posedge clk); @(posedge clk); #1;
    mq.delete(); mfault = 0; mcause = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    push_5a = 1; to_push_5a = 35'h55;
    do_reset();
    idle_inputs();
    #1;
    n_checks++;
    if (count !== '0 || fault !== 1'b0 || fault_cause !== 2'b00 || top_2a !== '0)
      $display("FAIL reset: got cnt=%0d f=%b c=%b top=%h want 0", count, fault, fault_cause, top_2a);
    else n_pass++;
    rst_b = 1;
  endtask

  task automatic test_push_basic();
    for (int i = 1; i <= 3; i++) cycle(1, W'(i), 0, '0, 0, 0, '0);
    n_checks++;
    if (count !== 7'd3 || top_2a[W-1:0] !== 35'h3 || top_2a[2*W-1:W] !== 35'h2 || fault !== 1'b0)
      $display("FAIL push_basic: got cnt=%0d s0=%h s1=%h want 3/3/2", count, top_2a[W-1:0], top_2a[2*W-1:W]);
    else n_pass++;
  endtask

  task automatic test_replace();
    cycle(1, 35'h7, 1, 11'd1, 0, 0, '0);
    n_checks++;
    if (count !== 7'd3 || top_2a[W-1:0] !== 35'h7 || top_2a[2*W-1:W] !== 35'h2)
      $display("FAIL replace: got cnt=%0d s0=%h s1=%h want 3/7/2", count, top_2a[W-1:0], top_2a[2*W-1:W]);
    else n_pass++;
  endtask

  task automatic test_underflow();
    cycle(0, '0, 0, '0, 1, 0, '0);
    cycle(1, 35'h11, 0, '0, 0, 0, '0);
    cycle(0, '0, 1, 11'd2, 0, 0, '0);
    n_checks++;
    if (count !== 7'd0 || fault !== 1'b1 || fault_cause !== 2'b10)
      $display("FAIL underflow: got cnt=%0d f=%b c=%b want 0/1/10", count, fault, fault_cause);
    else n_pass++;
    cycle(1, 35'h22, 0, '0, 0, 0, '0);
    n_checks++;
    if (count !== 7'd0 || stall_2a !== 1'b1)
      $display("FAIL fault_frozen: got cnt=%0d stall=%b want 0/1", count, stall_2a);
    else n_pass++;
    cycle(0, '0, 0, '0, 1, 0, '0);
    n_checks++;
    if (fault !== 1'b0 || count !== 7'd0)
      $display("FAIL clear: got f=%b cnt=%0d want 0/0", fault, count);
    else n_pass++;
    // Pop count above 2^CNT_W must still be seen as underflow.
    cycle(0, '0, 1, 11'd1200, 0, 0, '0);
    cycle(0, '0, 0, '0, 1, 0, '0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) cycle(1, W'(32'h100 + i), 0, '0, 0, 0, '0);
    cycle(1, 35'hAA, 0, '0, 0, 0, '0);
    n_checks++;
    if (count !== 7'd64 || fault_cause !== 2'b01 || top_2a[W-1:0] !== W'(32'h100 + D - 1))
      $display("FAIL overflow: got cnt=%0d c=%b s0=%h want 64/01/%h",
               count, fault_cause, top_2a[W-1:0], W'(32'h100 + D - 1));
    else n_pass++;
    cycle(0, '0, 0, '0, 1, 0, '0);
  endtask

  task automatic test_stall();
    cycle(0, '0, 0, '0, 0, 3'd2, 2'b01);
    cycle(0, '0, 0, '0, 0, 3'd2, 2'b00);
    cycle(0, '0, 0, '0, 0, 3'd0, 2'b11);
    cycle(0, '0, 0, '0, 0, 3'd7, 2'b10);
    need_2a = 3'd2; inflight_mod = 2'b01; #1;
    n_checks++;
    if (stall_2a !== 1'b1) $display("FAIL stall_inflight: got %b want 1", stall_2a);
    else n_pass++;
    need_2a = 3'd0; inflight_mod = 2'b11; #1;
    n_checks++;
    if (stall_2a !== 1'b0) $display("FAIL stall_noneed: got %b want 0", stall_2a);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [W-1:0] old_top;
    cycle(0, '0, 0, '0, 1, 0, '0);
    cycle(1, 35'h3A, 0, '0, 0, 0, '0);
    cycle(1, 35'h3B, 0, '0, 0, 0, '0);
    old_top = mq[mq.size()-1];
    push_5a = 1; to_push_5a = 35'h5; need_2a = 3'd1; #1;
    n_checks++;
    if (BYP ? (stall_2a !== 1'b0 || top_2a[W-1:0] !== 35'h5)
            : (stall_2a !== 1'b1 || top_2a[W-1:0] !== old_top))
      $display("FAIL bypass: got stall=%b s0=%h want %b/%h", stall_2a, top_2a[W-1:0],
               !BYP, BYP ? 35'h5 : old_top);
    else n_pass++;
    cycle(1, 35'h5, 0, '0, 0, 3'd1, '0);
  endtask

  task automatic test_reset_mid();
    cycle(1, 35'h44, 0, '0, 0, 0, '0);
    push_5a = 1; to_push_5a = 35'h66;
    do_reset();
    idle_inputs();
    #1;
    n_checks++;
    if (count !== '0 || top_2a !== '0) $display("FAIL reset_mid: got cnt=%0d top=%h want 0", count, top_2a);
    else n_pass++;
    rst_b = 1;
  endtask

  task automatic test_random();
    logic         psh, pp, clr;
    logic [P-1:0] n;
    for (int i = 0; i < 600; i++) begin
      // Phases bias towards growth or shrinkage so both fault kinds occur.
      psh = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 80 : 35));
      pp  = ($urandom_range(0, 99) < 40);
      n   = ($urandom_range(0, 49) == 0) ? P'($urandom_range(129, 2047)) : P'($urandom_range(0, 3));
      clr = mfault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      cycle(psh, W'({$urandom, $urandom}), pp, n, clr, 3'($urandom_range(0, 7)), IF'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    idle_inputs();
    rst_b = 0;
    mfault = 0; mcause = 2'b00;
    test_reset();
    test_push_basic();
    test_replace();
    test_underflow();
    test_overflow();
    test_stall();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
